// File: rtl/rx_phy_pkg.sv
// Shared definitions for the 802.11a receive-side symbol control path:
// FSM state codes, RATE field codes and deinterleaver block-size selects.
package rx_phy_pkg;

   localparam int SIG_CODED_BITS = 48;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SIGNAL   = 3'd1;
   localparam logic [2:0] ST_WAIT_SIG = 3'd2;
   localparam logic [2:0] ST_DATA     = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;
   localparam logic [2:0] ST_ERROR    = 3'd5;

   localparam logic [3:0] RATE_6M  = 4'b1101;
   localparam logic [3:0] RATE_9M  = 4'b1111;
   localparam logic [3:0] RATE_12M = 4'b0101;
   localparam logic [3:0] RATE_18M = 4'b0111;
   localparam logic [3:0] RATE_24M = 4'b1001;
   localparam logic [3:0] RATE_36M = 4'b1011;
   localparam logic [3:0] RATE_48M = 4'b0001;
   localparam logic [3:0] RATE_54M = 4'b0011;

   localparam logic [1:0] NCBPS_48  = 2'd0;
   localparam logic [1:0] NCBPS_96  = 2'd1;
   localparam logic [1:0] NCBPS_192 = 2'd2;
   localparam logic [1:0] NCBPS_288 = 2'd3;

   function automatic logic [8:0] ncbps_of(input logic [1:0] sel);
      case (sel)
         NCBPS_48:  ncbps_of = 9'd48;
         NCBPS_96:  ncbps_of = 9'd96;
         NCBPS_192: ncbps_of = 9'd192;
         default:   ncbps_of = 9'd288;
      endcase
   endfunction

endpackage

// File: rtl/rx_rate_lut.sv
// Combinational decode of the 4-bit RATE field into data bits per symbol
// and deinterleaver block-size select; flags codes that are not legal rates.
module rx_rate_lut
   import rx_phy_pkg::*;
(
   input  logic [3:0] rate,
   output logic       valid,
   output logic [7:0] ndbps,
   output logic [1:0] ncbps_sel
);

   always_comb begin
      valid     = 1'b1;
      ndbps     = 8'd0;
      ncbps_sel = NCBPS_48;
      case (rate)
         RATE_6M:  begin ndbps = 8'd24;  ncbps_sel = NCBPS_48;  end
         RATE_9M:  begin ndbps = 8'd36;  ncbps_sel = NCBPS_48;  end
         RATE_12M: begin ndbps = 8'd48;  ncbps_sel = NCBPS_96;  end
         RATE_18M: begin ndbps = 8'd72;  ncbps_sel = NCBPS_96;  end
         RATE_24M: begin ndbps = 8'd96;  ncbps_sel = NCBPS_192; end
         RATE_36M: begin ndbps = 8'd144; ncbps_sel = NCBPS_192; end
         RATE_48M: begin ndbps = 8'd192; ncbps_sel = NCBPS_288; end
         RATE_54M: begin ndbps = 8'd216; ncbps_sel = NCBPS_288; end
         default:  valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/rx_symbol_sequencer.sv
// Frame controller: gates coded bits into the deinterleaver one OFDM symbol
// at a time, holds upstream during SIGNAL decode, and frames DATA symbols.
module rx_symbol_sequencer
   import rx_phy_pkg::*;
#(
   parameter int SIG_BITS    = SIG_CODED_BITS,
   parameter int SIG_TIMEOUT = 255,
   parameter int REM_W       = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx_data,
   input  logic        bit_valid,
   input  logic        in_bit,
   input  logic        sig_valid,
   input  logic [3:0]  sig_rate,
   input  logic [11:0] sig_length,
   input  logic        sig_parity_ok,
   output logic        rx_ready,
   output logic        deint_bit,
   output logic        deint_valid,
   output logic [1:0]  deint_ncbps_sel,
   output logic        sym_start,
   output logic        sym_end,
   output logic        data_phase,
   output logic [10:0] sym_count,
   output logic        rx_end,
   output logic        rx_error
);

   localparam int TW = $clog2(SIG_TIMEOUT + 1);

   logic [2:0]       state;
   logic [2:0]       next_state;
   logic [8:0]       bit_cnt;
   logic [8:0]       sym_len;
   logic [TW-1:0]    timer;
   logic [REM_W-1:0] remaining;
   logic [7:0]       ndbps;
   logic             accept;
   logic             sym_first;
   logic             sym_last;
   logic             last_data;
   logic             sig_good;
   logic             lut_valid;
   logic [7:0]       lut_ndbps;
   logic [1:0]       lut_sel;

   rx_rate_lut u_rate_lut (
      .rate      (sig_rate),
      .valid     (lut_valid),
      .ndbps     (lut_ndbps),
      .ncbps_sel (lut_sel)
   );

   // Carrier loss wins over a same-cycle bit, so rx_data gates acceptance.
   assign rx_ready   = (state == ST_SIGNAL) || (state == ST_DATA);
   assign data_phase = (state == ST_DATA);
   assign accept     = bit_valid && rx_ready && rx_data;
   assign sym_len    = (state == ST_DATA) ? ncbps_of(deint_ncbps_sel) : 9'(SIG_BITS);
   assign sym_first  = (bit_cnt == 9'd0);
   assign sym_last   = (bit_cnt == sym_len - 9'd1);
   assign last_data  = (remaining <= REM_W'(ndbps));
   assign sig_good   = sig_parity_ok && lut_valid && (sig_length != 12'd0);

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:     if (rx_data) next_state = ST_SIGNAL;
         ST_SIGNAL: begin
            if (!rx_data)                next_state = ST_ERROR;
            else if (accept && sym_last) next_state = ST_WAIT_SIG;
         end
         ST_WAIT_SIG: begin
            if (!rx_data)                      next_state = ST_ERROR;
            else if (sig_valid)                next_state = sig_good ? ST_DATA : ST_ERROR;
            else if (timer == TW'(SIG_TIMEOUT)) next_state = ST_ERROR;
         end
         ST_DATA: begin
            if (!rx_data)                             next_state = ST_ERROR;
            else if (accept && sym_last && last_data) next_state = ST_DONE;
         end
         ST_DONE, ST_ERROR: if (!rx_data) next_state = ST_IDLE;
         default:     next_state = ST_IDLE;
      endcase
   end

   // rx_end fires the cycle after the final deint_valid, i.e. once the
   // registered last-bit strobe is seen while already sitting in DONE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= ST_IDLE;
         deint_bit       <= 1'b0;
         deint_valid     <= 1'b0;
         sym_start       <= 1'b0;
         sym_end         <= 1'b0;
         rx_end          <= 1'b0;
         rx_error        <= 1'b0;
         deint_ncbps_sel <= NCBPS_48;
         sym_count       <= 11'd0;
         bit_cnt         <= 9'd0;
         timer           <= '0;
         remaining       <= '0;
         ndbps           <= 8'd0;
      end else begin
         state       <= next_state;
         deint_valid <= accept;
         sym_start   <= accept && sym_first;
         sym_end     <= accept && sym_last;
         rx_error    <= (next_state == ST_ERROR) && (state != ST_ERROR);
         rx_end      <= (state == ST_DONE) && deint_valid && sym_end;
         if (accept) deint_bit <= in_bit;

         case (state)
            ST_IDLE: begin
               if (rx_data) begin
                  bit_cnt         <= 9'd0;
                  sym_count       <= 11'd0;
                  deint_ncbps_sel <= NCBPS_48;
               end
            end
            ST_SIGNAL: begin
               timer <= '0;
               if (accept) bit_cnt <= sym_last ? 9'd0 : bit_cnt + 9'd1;
            end
            ST_WAIT_SIG: begin
               timer <= timer + TW'(1);
               if (sig_valid && sig_good) begin
                  ndbps           <= lut_ndbps;
                  deint_ncbps_sel <= lut_sel;
                  remaining       <= REM_W'(22) + REM_W'({sig_length, 3'b000});
                  bit_cnt         <= 9'd0;
               end
            end
            ST_DATA: begin
               if (accept) begin
                  if (sym_last) begin
                     bit_cnt   <= 9'd0;
                     sym_count <= sym_count + 11'd1;
                     if (!last_data) remaining <= remaining - REM_W'(ndbps);
                  end else begin
                     bit_cnt <= bit_cnt + 9'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_symbol_sequencer.sv
// Directed frames against a frame-level model (symbol count from ceil division),
// compared every cycle, plus literal expectations per frame.
module tb_rx_symbol_sequencer;

   localparam int P_IDLE = 0, P_SIG = 1, P_WAIT = 2, P_DATA = 3, P_DONE = 4, P_ERR = 5;

   logic        clock, reset, rx_data, bit_valid, in_bit, sig_valid, sig_parity_ok;
   logic [3:0]  sig_rate;
   logic [11:0] sig_length;
   logic        rx_ready, deint_bit, deint_valid, sym_start, sym_end, data_phase, rx_end, rx_error;
   logic [1:0]  deint_ncbps_sel;
   logic [10:0] sym_count;

   int checks = 0, errors = 0;
   int cyc = 0, n_valid = 0, n_end = 0, n_err = 0, err_cyc = 0, sig_end_cyc = 0;
   bit rand_mode = 0;

   int m_ph, m_bits, m_wt, m_nsym, m_ncb, m_symcnt;
   bit m_pend;
   logic e_ready, e_bit, e_valid, e_start, e_end, e_phase, e_rx_end, e_rx_err;
   logic [1:0] e_sel;
   int e_symcnt;

   rx_symbol_sequencer dut (
      .clock(clock), .reset(reset), .rx_data(rx_data), .bit_valid(bit_valid), .in_bit(in_bit),
      .sig_valid(sig_valid), .sig_rate(sig_rate), .sig_length(sig_length),
      .sig_parity_ok(sig_parity_ok), .rx_ready(rx_ready), .deint_bit(deint_bit),
      .deint_valid(deint_valid), .deint_ncbps_sel(deint_ncbps_sel), .sym_start(sym_start),
      .sym_end(sym_end), .data_phase(data_phase), .sym_count(sym_count), .rx_end(rx_end),
      .rx_error(rx_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   function automatic void rate_info(input logic [3:0] r, output bit ok, output int nd,
                                     output int nc, output int sl);
      ok = 1;
      case (r)
         4'b1101: begin nd = 24;  nc = 48;  sl = 0; end
         4'b1111: begin nd = 36;  nc = 48;  sl = 0; end
         4'b0101: begin nd = 48;  nc = 96;  sl = 1; end
         4'b0111: begin nd = 72;  nc = 96;  sl = 1; end
         4'b1001: begin nd = 96;  nc = 192; sl = 2; end
         4'b1011: begin nd = 144; nc = 192; sl = 2; end
         4'b0001: begin nd = 192; nc = 288; sl = 3; end
         4'b0011: begin nd = 216; nc = 288; sl = 3; end
         default: begin ok = 0; nd = 1; nc = 48; sl = 0; end
      endcase
   endfunction

   // Frame model: bit position within the frame decides the symbol framing.
   always @(posedge clock or negedge reset) begin : model
      bit acc, ok;
      int nd, nc, sl, pos, len_bits;
      if (!reset) begin
         m_ph = P_IDLE; m_bits = 0; m_wt = 0; m_nsym = 0; m_ncb = 48; m_symcnt = 0; m_pend = 0;
         e_bit = 0; e_valid = 0; e_start = 0; e_end = 0; e_rx_end = 0; e_rx_err = 0; e_sel = 0;
      end else begin
         acc = bit_valid && rx_data && (m_ph == P_SIG || m_ph == P_DATA);
         e_valid = acc;
         if (acc) e_bit = in_bit;
         e_start = 0; e_end = 0; e_rx_end = 0; e_rx_err = 0;
         case (m_ph)
            P_IDLE: if (rx_data) begin m_ph = P_SIG; m_bits = 0; m_symcnt = 0; e_sel = 0; end
            P_SIG: begin
               if (!rx_data) begin m_ph = P_ERR; e_rx_err = 1; end
               else if (acc) begin
                  e_start = (m_bits == 0); e_end = (m_bits == 47); m_bits++;
                  if (m_bits == 48) begin m_ph = P_WAIT; m_wt = 0; end
               end
            end
            P_WAIT: begin
               if (!rx_data) begin m_ph = P_ERR; e_rx_err = 1; end
               else if (sig_valid) begin
                  rate_info(sig_rate, ok, nd, nc, sl);
                  if (ok && sig_parity_ok && sig_length != 0) begin
                     len_bits = 22 + 8 * int'(sig_length);
                     m_nsym = (len_bits + nd - 1) / nd;
                     m_ncb = nc; e_sel = 2'(sl); m_bits = 0; m_ph = P_DATA;
                  end else begin m_ph = P_ERR; e_rx_err = 1; end
               end
               else if (m_wt == 255) begin m_ph = P_ERR; e_rx_err = 1; end
               else m_wt++;
            end
            P_DATA: begin
               if (!rx_data) begin m_ph = P_ERR; e_rx_err = 1; end
               else if (acc) begin
                  pos = m_bits % m_ncb;
                  e_start = (pos == 0); e_end = (pos == m_ncb - 1); m_bits++;
                  if (pos == m_ncb - 1) m_symcnt++;
                  if (m_bits == m_nsym * m_ncb) begin m_ph = P_DONE; m_pend = 1; end
               end
            end
            P_DONE: begin
               if (m_pend) begin e_rx_end = 1; m_pend = 0; end
               if (!rx_data) m_ph = P_IDLE;
            end
            default: if (!rx_data) m_ph = P_IDLE;
         endcase
      end
   end

   always_comb begin
      e_ready  = (m_ph == P_SIG) || (m_ph == P_DATA);
      e_phase  = (m_ph == P_DATA);
      e_symcnt = m_symcnt;
   end

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic checkOutput();
      cmp("rx_ready", int'(rx_ready), int'(e_ready));
      cmp("deint_valid", int'(deint_valid), int'(e_valid));
      cmp("deint_bit", int'(deint_bit), int'(e_bit));
      cmp("sym_start", int'(sym_start), int'(e_start));
      cmp("sym_end", int'(sym_end), int'(e_end));
      cmp("data_phase", int'(data_phase), int'(e_phase));
      cmp("ncbps_sel", int'(deint_ncbps_sel), int'(e_sel));
      cmp("sym_count", int'(sym_count), e_symcnt);
      cmp("rx_end", int'(rx_end), int'(e_rx_end));
      cmp("rx_error", int'(rx_error), int'(e_rx_err));
   endtask

   always @(negedge clock) begin
      if (deint_valid) n_valid++;
      if (rx_end) n_end++;
      if (rx_error) begin n_err++; err_cyc = cyc; end
      if (sym_end && m_ph == P_WAIT) sig_end_cyc = cyc;
      checkOutput();
   end

   task automatic tick();
      @(posedge clock);
      #1;
      in_bit = 1'($urandom);
      bit_valid = rand_mode ? 1'($urandom) : 1'b1;
   endtask

   task automatic applyStimulus(input logic [3:0] rate, input int len, input bit parity,
                                input bit send_sig, input bit rand_valid, input int drop_at,
                                input int stop_at, input bit stray);
      int guard;
      rand_mode = rand_valid;
      n_valid = 0; n_end = 0; n_err = 0;
      sig_rate = rate; sig_length = 12'(len); sig_parity_ok = parity;
      rx_data = 1'b1;
      guard = 0;
      while (m_ph != P_WAIT && m_ph != P_ERR && guard < 400) begin tick(); guard++; end
      if (guard >= 400) cmp("signal_phase_timeout", guard, 0);
      if (send_sig) begin
         repeat (4) tick();
         sig_valid = 1'b1; tick(); sig_valid = 1'b0;
      end
      guard = 0;
      while (m_ph != P_DONE && m_ph != P_ERR && guard < 5000) begin
         if (m_ph == P_DATA && m_bits == stop_at) return;
         if (m_ph == P_DATA && m_bits == drop_at) rx_data = 1'b0;
         sig_valid = stray && m_ph == P_DATA && m_bits == 100;
         if (sig_valid) sig_parity_ok = 1'b0;
         tick(); guard++;
      end
      sig_valid = 1'b0;
      if (guard >= 5000) cmp("frame_timeout", guard, 0);
      repeat (2) tick();
      rx_data = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      reset = 1'b0; rx_data = 0; bit_valid = 0; in_bit = 0; sig_valid = 0;
      sig_rate = 0; sig_length = 0; sig_parity_ok = 0;
      repeat (3) @(posedge clock);
      #3 reset = 1'b1;
      tick();
      cmp("reset_rx_ready", int'(rx_ready), 0);
      cmp("reset_sym_count", int'(sym_count), 0);

      // 6 Mbps, one octet: 48 SIGNAL bits + 2 symbols of 48
      applyStimulus(4'b1101, 1, 1, 1, 0, -1, -1, 0);
      cmp("f1_valid_bits", n_valid, 144);
      cmp("f1_rx_end", n_end, 1);
      cmp("f1_sym_count", int'(sym_count), 2);

      // 54 Mbps, 100 octets, with a stray sig_valid during DATA
      applyStimulus(4'b0011, 100, 1, 1, 0, -1, -1, 1);
      cmp("f2_valid_bits", n_valid, 48 + 4 * 288);
      cmp("f2_rx_end", n_end, 1);
      cmp("f2_rx_error", n_err, 0);
      cmp("f2_sym_count", int'(sym_count), 4);
      cmp("f2_ncbps_sel", int'(deint_ncbps_sel), 3);

      // Illegal RATE code
      applyStimulus(4'b0000, 5, 1, 1, 0, -1, -1, 0);
      cmp("f3_rx_error", n_err, 1);
      cmp("f3_valid_bits", n_valid, 48);
      cmp("f3_idle_ready", int'(rx_ready), 0);

      // SIGNAL decode never returns
      applyStimulus(4'b1101, 1, 1, 0, 1, -1, -1, 0);
      cmp("f4_rx_error", n_err, 1);
      cmp("f4_valid_bits", n_valid, 48);
      cmp("f4_timeout_cycles", err_cyc - sig_end_cyc, 256);

      // Carrier loss in the second 24 Mbps symbol, then a clean frame
      applyStimulus(4'b1001, 200, 1, 1, 0, 242, -1, 0);
      cmp("f5_rx_error", n_err, 1);
      cmp("f5_rx_end", n_end, 0);
      cmp("f5_valid_bits", n_valid, 48 + 242);
      applyStimulus(4'b1101, 1, 1, 1, 0, -1, -1, 0);
      cmp("f6_rx_end", n_end, 1);
      cmp("f6_sym_count", int'(sym_count), 2);

      // Async reset mid DATA, then 12 Mbps length 10 (102 bits / 48 -> 3 symbols)
      applyStimulus(4'b0101, 10, 1, 1, 0, -1, 30, 0);
      #2 reset = 1'b0;
      #1;
      cmp("async_reset_outputs",
          int'({rx_ready, deint_bit, deint_valid, deint_ncbps_sel, sym_start, sym_end,
                data_phase, sym_count, rx_end, rx_error}), 0);
      rx_data = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      applyStimulus(4'b0101, 10, 1, 1, 0, -1, -1, 0);
      cmp("f7_rx_end", n_end, 1);
      cmp("f7_rx_error", n_err, 0);
      cmp("f7_valid_bits", n_valid, 48 + 3 * 96);
      cmp("f7_sym_count", int'(sym_count), 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
